// File: rtl/pool_row_sequencer.sv
// pool_row_sequencer: row-level controller for the max-pool stage.
// Streams cfg_rows rows of cfg_col words from the feature buffer into the
// pool datapath. Between rows it waits for pool_end, then holds valid_in low
// for GAP_CYC cycles so the datapath sees a clean row start.
// Optional feature: define POOL_SEQ_TIMEOUT_EN to add a WAIT-state watchdog
// that flags err and forces the row complete after TMO_CYC cycles.
module pool_row_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int ROW_W   = 10,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              abort,
    input  logic              cfg_pool_en,
    input  logic              cfg_layer1,
    input  logic [15:0]       cfg_col,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              pool_end,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              valid_in,
    output logic              pool_en,
    output logic              layer1,
    output logic [15:0]       col,
    output logic [ROW_W-1:0]  row_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        word_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [ROW_W-1:0]   rows_q;
    logic               cfg_ok;
    logic               last_word;
    logic               gap_last;
    logic               abort_hit;
    logic               tmo_hit;

    assign cfg_ok    = (cfg_col != 16'd0) && (cfg_rows != '0);
    assign last_word = (word_cnt == col - 16'd1);
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));
    assign abort_hit = abort && (state != S_IDLE);

    assign rd_en = (state == S_STREAM);
    assign busy  = (state != S_IDLE) && (state != S_FIN);
    assign done  = (state == S_FIN) && !abort;

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // An empty job spends its one busy cycle in GAP with rows_q=0,
                // which then falls straight through to FIN.
                if (cfg_start) state_nxt = cfg_ok ? S_STREAM : S_GAP;
            end
            S_STREAM: begin
                if (last_word) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (pool_end || tmo_hit) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = (row_cnt < rows_q) ? S_STREAM : S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    // State register plus config latch, address, word/gap/row counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            valid_in <= 1'b0;
            pool_en  <= 1'b0;
            layer1   <= 1'b0;
            col      <= 16'd0;
            rows_q   <= '0;
            rd_addr  <= '0;
            row_cnt  <= '0;
            word_cnt <= 16'd0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            valid_in <= rd_en;
            if (!abort_hit) begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            pool_en  <= cfg_pool_en;
                            layer1   <= cfg_layer1;
                            col      <= cfg_col;
                            rows_q   <= cfg_ok ? cfg_rows : '0;
                            rd_addr  <= cfg_base;
                            row_cnt  <= '0;
                            word_cnt <= 16'd0;
                            gap_cnt  <= cfg_ok ? '0 : GAP_W'(GAP_CYC - 1);
                        end
                    end
                    S_STREAM: begin
                        // Address keeps running across rows; wraps at 2^ADDR_W.
                        rd_addr  <= rd_addr + ADDR_W'(1);
                        word_cnt <= last_word ? 16'd0 : word_cnt + 16'd1;
                    end
                    S_WAIT: begin
                        if (pool_end || tmo_hit) begin
                            row_cnt <= row_cnt + ROW_W'(1);
                            gap_cnt <= '0;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef POOL_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    // WAIT watchdog: counter restarts on every WAIT entry; err is sticky until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if ((state == S_IDLE) && cfg_start)
                err <= 1'b0;
            else if (tmo_hit && !pool_end && !abort)
                err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_pool_row_sequencer.sv
// Testbench for pool_row_sequencer: table-driven jobs, hand-written abort and
// watchdog sequences, and randomized jobs checked cycle by cycle against an
// event-schedule model built from row/gap arithmetic.
module tb_pool_row_sequencer;

    localparam int ADDR_W  = 12;
    localparam int ROW_W   = 10;
    localparam int GAP_CYC = 2;
    localparam int TMO_CYC = 64;
    localparam int LEN     = 256;

    logic              clk;
    logic              rst_n;
    logic              cfg_start;
    logic              abort;
    logic              cfg_pool_en;
    logic              cfg_layer1;
    logic [15:0]       cfg_col;
    logic [ROW_W-1:0]  cfg_rows;
    logic [ADDR_W-1:0] cfg_base;
    logic              pool_end;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              valid_in;
    logic              pool_en;
    logic              layer1;
    logic [15:0]       col;
    logic [ROW_W-1:0]  row_cnt;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    pool_row_sequencer #(
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .GAP_CYC(GAP_CYC),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .abort      (abort),
        .cfg_pool_en(cfg_pool_en),
        .cfg_layer1 (cfg_layer1),
        .cfg_col    (cfg_col),
        .cfg_rows   (cfg_rows),
        .cfg_base   (cfg_base),
        .pool_end   (pool_end),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .valid_in   (valid_in),
        .pool_en    (pool_en),
        .layer1     (layer1),
        .col        (col),
        .row_cnt    (row_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          c;
        int          r;
        logic [11:0] b;
        bit          pe;
        bit          l1;
        int          dly;
        bit          mid;
        int          exp_done;
        int          exp_rc;
    } vec_t;

    vec_t vt[6];

    bit          e_rd   [LEN];
    logic [11:0] e_addr [LEN];
    bit          e_busy [LEN];
    bit          e_done [LEN];
    bit          e_pe   [LEN];
    int          e_rc   [LEN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        cfg_start = 1'b0;
        abort     = 1'b0;
        pool_end  = 1'b0;
    endtask

    // One job: build the expected per-cycle schedule from row arithmetic,
    // drive start and pool_end from that schedule, compare every cycle.
    // dly < 0 picks a random WAIT delay per row; spur adds ignored pool_end
    // pulses during STREAM; mid pulses a conflicting start at cycle 2.
    task automatic run_job(input int c, input int r, input logic [11:0] b,
                           input bit pe, input bit l1, input int dly,
                           input bit spur, input bit mid,
                           output int done_at, output int rc_end);
        int  s, w, p, len, rowd, cnt;
        int  pq[$];
        bit  nz;
        for (int k = 0; k < LEN; k++) begin
            e_rd[k] = 0; e_addr[k] = '0; e_busy[k] = 0;
            e_done[k] = 0; e_pe[k] = 0; e_rc[k] = 0;
        end
        nz = (c != 0) && (r != 0);
        if (!nz) begin
            e_busy[1] = 1;
            e_done[2] = 1;
            len = 4;
        end else begin
            s = 1;
            for (int i = 0; i < r; i++) begin
                for (int j = 0; j < c; j++) begin
                    e_rd[s + j]   = 1;
                    e_addr[s + j] = 12'(int'(b) + i * c + j);
                end
                if (spur && ($urandom_range(0, 2) == 0))
                    e_pe[s + int'($urandom_range(0, c - 1))] = 1;
                w    = s + c;
                rowd = (dly >= 0) ? dly : int'($urandom_range(0, 5));
                p    = w + rowd;
                e_pe[p] = 1;
                pq.push_back(p);
                s = p + GAP_CYC + 1;
            end
            e_done[s] = 1;
            for (int k = 1; k < s; k++) e_busy[k] = 1;
            len = s + 3;
            for (int k = 0; k < len; k++) begin
                cnt = 0;
                foreach (pq[q]) if (pq[q] < k) cnt++;
                e_rc[k] = cnt;
            end
        end
        done_at = -1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk("rd_en", rd_en, e_rd[k]);
            if (e_rd[k]) chk("rd_addr", rd_addr, e_addr[k]);
            chk("valid_in", valid_in, (k > 0) ? e_rd[k-1] : 1'b0);
            chk("busy", busy, e_busy[k]);
            chk("done", done, e_done[k]);
            if (nz && k >= 1) begin
                chk("row_cnt", row_cnt, e_rc[k]);
                chk("col_hold", col, c);
                chk("pool_en_hold", pool_en, pe);
                chk("layer1_hold", layer1, l1);
            end
            if (done && done_at < 0) done_at = k;
            if (mid && nz && k == 2) begin
                cfg_start   = 1'b1;
                cfg_col     = 16'(c + 1);
                cfg_rows    = ROW_W'(r + 1);
                cfg_base    = b + 12'd7;
                cfg_pool_en = ~pe;
                cfg_layer1  = ~l1;
            end else begin
                cfg_start   = (k == 0);
                cfg_col     = 16'(c);
                cfg_rows    = ROW_W'(r);
                cfg_base    = b;
                cfg_pool_en = pe;
                cfg_layer1  = l1;
            end
            pool_end = e_pe[k];
        end
        drive_idle();
        rc_end = int'(row_cnt);
    endtask

    initial begin
        int da, rc, c, r;
        rst_n = 1'b0;
        drive_idle();
        cfg_pool_en = 1'b1; cfg_layer1 = 1'b1;
        cfg_col = 16'd5; cfg_rows = 10'd3; cfg_base = 12'hABC;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid_in", valid_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pool_en", pool_en, 0);
        chk("rst_layer1", layer1, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_col", col, 0);
        chk("rst_row_cnt", row_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven jobs: expected done cycle = rows*(col+dly+GAP+1)+1
        vt[0] = '{4, 1, 12'h010, 1'b1, 1'b0, 2, 1'b0, 10, 1};
        vt[1] = '{3, 3, 12'hFFE, 1'b0, 1'b1, 0, 1'b0, 19, 3};
        vt[2] = '{5, 0, 12'h020, 1'b1, 1'b1, 0, 1'b0,  2, -1};
        vt[3] = '{0, 2, 12'h030, 1'b0, 1'b0, 0, 1'b0,  2, -1};
        vt[4] = '{2, 2, 12'h3FF, 1'b1, 1'b0, 1, 1'b1, 13, 2};
        vt[5] = '{1, 4, 12'h000, 1'b0, 1'b1, 3, 1'b0, 29, 4};
        for (int v = 0; v < 6; v++) begin
            run_job(vt[v].c, vt[v].r, vt[v].b, vt[v].pe, vt[v].l1, vt[v].dly,
                    1'b0, vt[v].mid, da, rc);
            chk($sformatf("vec%0d_done_cycle", v), da, vt[v].exp_done);
            if (vt[v].exp_rc >= 0) chk($sformatf("vec%0d_row_cnt", v), rc, vt[v].exp_rc);
        end

        // Abort during the second row's STREAM
        cfg_col = 16'd4; cfg_rows = 10'd3; cfg_base = 12'h100;
        cfg_pool_en = 1'b1; cfg_layer1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 8) begin
                chk("abort_row1_rd_en", rd_en, 1);
                chk("abort_row1_addr", rd_addr, 12'h104);
                chk("abort_row1_row_cnt", row_cnt, 1);
            end
            if (k == 10) begin
                chk("abort_rd_en", rd_en, 0);
                chk("abort_busy", busy, 0);
                chk("abort_row_cnt", row_cnt, 1);
            end
            if (k >= 10) chk("abort_no_done", done, 0);
            cfg_start = (k == 0);
            pool_end  = (k == 5);
            abort     = (k == 9);
        end
        drive_idle();
        run_job(2, 1, 12'h050, 1'b0, 1'b1, 0, 1'b0, 1'b0, da, rc);
        chk("after_abort_done_cycle", da, 6);
        chk("after_abort_row_cnt", rc, 1);

`ifdef POOL_SEQ_TIMEOUT_EN
        // Watchdog: first row never gets pool_end
        cfg_col = 16'd2; cfg_rows = 10'd2; cfg_base = 12'h200;
        for (int k = 0; k < 87; k++) begin
            @(negedge clk);
            if (k == 66) begin
                chk("tmo_err_before", err, 0);
                chk("tmo_busy_wait", busy, 1);
            end
            if (k == 67) begin
                chk("tmo_err_set", err, 1);
                chk("tmo_row_counted", row_cnt, 1);
            end
            if (k == 69) begin
                chk("tmo_row1_rd_en", rd_en, 1);
                chk("tmo_row1_addr", rd_addr, 12'h202);
            end
            if (k == 74) begin
                chk("tmo_done", done, 1);
                chk("tmo_err_sticky", err, 1);
            end
            if (k == 78) chk("tmo_err_cleared", err, 0);
            if (k == 83) chk("tmo_restart_done", done, 1);
            if (k == 77) begin
                cfg_col = 16'd1; cfg_rows = 10'd1; cfg_base = 12'h300;
            end
            cfg_start = (k == 0) || (k == 77);
            pool_end  = (k == 71) || (k == 80);
        end
        drive_idle();
`else
        // No watchdog: WAIT holds forever until aborted
        cfg_col = 16'd2; cfg_rows = 10'd1; cfg_base = 12'h200;
        for (int k = 0; k < 154; k++) begin
            @(negedge clk);
            if (k == 150) begin
                chk("nowd_busy", busy, 1);
                chk("nowd_rd_en", rd_en, 0);
                chk("nowd_err", err, 0);
                chk("nowd_row_cnt", row_cnt, 0);
            end
            if (k == 151) chk("nowd_abort_busy", busy, 0);
            if (k >= 3 && k <= 151 && done) chk("nowd_no_done", done, 0);
            cfg_start = (k == 0);
            abort     = (k == 150);
        end
        drive_idle();
`endif

        // Randomized jobs against the schedule model
        for (int n = 0; n < 25; n++) begin
            c = int'($urandom_range(1, 8));
            r = int'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) c = 0;
            if ($urandom_range(0, 7) == 0) r = 0;
            run_job(c, r, 12'($urandom), 1'($urandom), 1'($urandom), -1,
                    1'b1, 1'($urandom), da, rc);
            chk("rand_done_seen", (da >= 0), 1);
            if (c != 0 && r != 0) chk("rand_row_cnt", rc, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
